// File: rtl/wb_serial_tx.sv
// Wishbone classic slave feeding a TX FIFO that is drained by a framed serializer.
// Frame length, bit order and bit period are runtime-configurable through CTRL.
module wb_serial_tx #(
  parameter int unsigned DW      = 32,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned DIV_RST = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          CYC_I,
  input  logic          STB_I,
  input  logic          WE_I,
  input  logic [31:0]   ADR_I,
  input  logic [DW-1:0] DAT_I,
  output logic [DW-1:0] DAT_O,
  output logic          ACK_O,
  output logic          ena_o,
  output logic          data_o
);

  localparam int unsigned PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW   = $clog2(DEPTH + 1);
  localparam logic [5:0]  LenMax = 6'(DW - 1);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  // Bus side
  logic          ack_q, ack_d;
  logic [DW-1:0] dat_q, dat_d;

  // Control / status
  logic          ctrl_en_q, ctrl_en_d;
  logic          ctrl_lsb_q, ctrl_lsb_d;
  logic [5:0]    ctrl_len_q, ctrl_len_d;
  logic [15:0]   ctrl_div_q, ctrl_div_d;
  logic          ovf_q, ovf_d;

  // FIFO
  logic [DW-1:0]   mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  // Serializer
  state_e        state_q, state_d;
  logic [DW-1:0] shreg_q, shreg_d;
  logic [5:0]    bit_cnt_q, bit_cnt_d;
  logic [5:0]    len_f_q, len_f_d;
  logic [15:0]   div_cnt_q, div_cnt_d;
  logic [15:0]   div_f_q, div_f_d;
  logic          lsb_f_q, lsb_f_d;
  logic          ena_q, ena_d;
  logic          data_q, data_d;

  logic          access, bus_wr, push_req, ctrl_we, stat_we;
  logic          pop, push_ok, empty, full, busy, load, start_frame, cur_bit;
  logic [1:0]    adr;
  logic [31:0]   wdata32, rdata32, ctrl_word, status_word;
  logic [5:0]    len_clamped;
  logic [DW-1:0] fifo_head;
  logic          unused_bits;

  assign wdata32     = 32'(DAT_I);
  assign adr         = ADR_I[3:2];
  assign unused_bits = ^{ADR_I[31:4], ADR_I[1:0], wdata32[15:8]};

  // A fresh strobe is needed after each ack, so accesses come at most every other cycle.
  assign access   = CYC_I & STB_I & ~ack_q;
  assign bus_wr   = access & WE_I;
  assign push_req = bus_wr & (adr == 2'd0);
  assign ctrl_we  = bus_wr & (adr == 2'd1);
  assign stat_we  = bus_wr & (adr == 2'd2);

  assign empty     = (count_q == '0);
  assign full      = (count_q == CntW'(DEPTH));
  assign busy      = (state_q != StIdle);
  assign fifo_head = mem_q[rd_ptr_q];

  assign ctrl_word   = {ctrl_div_q, 8'h00, ctrl_len_q, ctrl_lsb_q, ctrl_en_q};
  assign status_word = {16'h0000, 8'(count_q), 4'h0, ovf_q, full, empty, busy};

  always_comb begin
    rdata32 = '0;
    unique case (adr)
      2'd1:    rdata32 = ctrl_word;
      2'd2:    rdata32 = status_word;
      default: rdata32 = '0;
    endcase
  end

  always_comb begin
    ack_d = access;
    dat_d = (access & ~WE_I) ? DW'(rdata32) : '0;
  end

  always_comb begin
    ctrl_en_d  = ctrl_en_q;
    ctrl_lsb_d = ctrl_lsb_q;
    ctrl_len_d = ctrl_len_q;
    ctrl_div_d = ctrl_div_q;
    if (ctrl_we) begin
      ctrl_en_d  = wdata32[0];
      ctrl_lsb_d = wdata32[1];
      ctrl_len_d = wdata32[7:2];
      ctrl_div_d = wdata32[31:16];
    end
  end

  // A push into a full FIFO still succeeds when the serializer pops in the same cycle.
  assign push_ok = push_req & (~full | pop);

  always_comb begin
    ovf_d = ovf_q;
    if (stat_we && wdata32[3]) begin
      ovf_d = 1'b0;
    end
    if (push_req && full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push_ok && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push_ok && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  assign len_clamped = (32'(ctrl_len_q) >= DW) ? LenMax : ctrl_len_q;
  assign start_frame = ctrl_en_q & ~empty;
  assign cur_bit     = lsb_f_q ? shreg_q[0] : shreg_q[DW-1];

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    len_f_d   = len_f_q;
    div_f_d   = div_f_q;
    lsb_f_d   = lsb_f_q;
    load      = 1'b0;
    pop       = 1'b0;

    unique case (state_q)
      StIdle: begin
        load = start_frame;
      end
      StShift: begin
        if (div_cnt_q == div_f_q) begin
          div_cnt_d = '0;
          shreg_d   = lsb_f_q ? (shreg_q >> 1) : (shreg_q << 1);
          if (bit_cnt_q == len_f_q) begin
            bit_cnt_d = '0;
            state_d   = StGap;
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end else begin
          div_cnt_d = div_cnt_q + 16'd1;
        end
      end
      StGap: begin
        if (div_cnt_q == div_f_q) begin
          div_cnt_d = '0;
          // Restart directly so back-to-back frames are spaced by exactly one bit period.
          if (start_frame) begin
            load = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          div_cnt_d = div_cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      pop       = 1'b1;
      state_d   = StShift;
      bit_cnt_d = '0;
      div_cnt_d = '0;
      len_f_d   = len_clamped;
      div_f_d   = ctrl_div_q;
      lsb_f_d   = ctrl_lsb_q;
      // MSB-first frames are left-aligned so the first bit always sits in the top position.
      shreg_d   = ctrl_lsb_q ? fifo_head : (fifo_head << (LenMax - len_clamped));
    end
  end

  always_comb begin
    ena_d  = (state_q == StShift);
    data_d = (state_q == StShift) & cur_bit;
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= DAT_I;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      ctrl_en_q  <= 1'b0;
      ctrl_lsb_q <= 1'b1;
      ctrl_len_q <= 6'd9;
      ctrl_div_q <= 16'(DIV_RST);
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= StIdle;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      len_f_q    <= '0;
      div_cnt_q  <= '0;
      div_f_q    <= '0;
      lsb_f_q    <= 1'b1;
      ena_q      <= 1'b0;
      data_q     <= 1'b0;
    end else begin
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      ctrl_en_q  <= ctrl_en_d;
      ctrl_lsb_q <= ctrl_lsb_d;
      ctrl_len_q <= ctrl_len_d;
      ctrl_div_q <= ctrl_div_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      len_f_q    <= len_f_d;
      div_cnt_q  <= div_cnt_d;
      div_f_q    <= div_f_d;
      lsb_f_q    <= lsb_f_d;
      ena_q      <= ena_d;
      data_q     <= data_d;
    end
  end

  assign ACK_O  = ack_q;
  assign DAT_O  = dat_q;
  assign ena_o  = ena_q;
  assign data_o = data_q;

endmodule

// File: tb/tb_wb_serial_tx.sv
// Directed and randomized bench for wb_serial_tx; serial output is compared against
// a cycle-level waveform built from word/length/divider/bit-order rules.
module tb_wb_serial_tx;

  logic        clk;
  logic        rst_i;
  logic        CYC_I, STB_I, WE_I;
  logic [31:0] ADR_I, DAT_I, DAT_O;
  logic        ACK_O, ena_o, data_o;

  int checks = 0;
  int errors = 0;
  int last_ack;

  logic [1:0] tr[$];     // {ena_o, data_o} sampled after every rising edge
  logic [1:0] exp_q[$];  // expected waveform for the current comparison

  wb_serial_tx #(.DW(32), .DEPTH(8), .DIV_RST(3)) dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .CYC_I  (CYC_I),
    .STB_I  (STB_I),
    .WE_I   (WE_I),
    .ADR_I  (ADR_I),
    .DAT_I  (DAT_I),
    .DAT_O  (DAT_O),
    .ACK_O  (ACK_O),
    .ena_o  (ena_o),
    .data_o (data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    tr.push_back({ena_o, data_o});
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the access is sampled on the following rising edge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ADR_I = {28'h0, a, 2'b00}; DAT_I = d;
    @(posedge clk); @(negedge clk);
    last_ack = tr.size() - 1;
    check("ack_wr", 32'(ACK_O), 32'd1);
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = {28'h0, a, 2'b00}; DAT_I = '0;
    @(posedge clk); @(negedge clk);
    last_ack = tr.size() - 1;
    check("ack_rd", 32'(ACK_O), 32'd1);
    d = DAT_O;
    CYC_I = 1'b0; STB_I = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  function automatic logic [31:0] ctrl_val(input int dv, input int len, input bit lsb,
                                           input bit en);
    return (32'(dv) << 16) | (32'(len) << 2) | (32'(lsb) << 1) | 32'(en);
  endfunction

  function automatic logic [31:0] status_val(input int lvl, input bit ovf, input bit busy);
    return (32'(lvl) << 8) | (32'(ovf) << 3) | ((lvl == 8) ? 32'h4 : 32'h0) |
           ((lvl == 0) ? 32'h2 : 32'h0) | 32'(busy);
  endfunction

  task automatic append_zeros(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(2'b00);
  endtask

  task automatic append_frame(input logic [31:0] w, input int len, input int dv, input bit lsb);
    int l;
    logic b;
    l = (len >= 32) ? 31 : len;
    for (int i = 0; i <= l; i++) begin
      b = lsb ? w[i] : w[l - i];
      for (int k = 0; k <= dv; k++) exp_q.push_back({1'b1, b});
    end
    append_zeros(dv + 1);
  endtask

  task automatic compare_stream(input string tag, input int start);
    int nmis;
    nmis = 0;
    while (tr.size() < start + exp_q.size()) @(negedge clk);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (tr[start + i] !== exp_q[i]) nmis++;
    end
    check(tag, 32'(nmis), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] words[$];
    logic [31:0] wa, wb;
    int n_ack, f, m, pops, cnt, len, dv, nw;
    bit lsb, bsy;

    rst_i = 1'b0; CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; ADR_I = '0; DAT_I = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", 32'(ACK_O), 32'd0);
    check("rst_dat", DAT_O, 32'd0);
    check("rst_ena", 32'(ena_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    rst_i = 1'b1;
    @(negedge clk);
    bus_read(2'd1, rd); check("rst_ctrl", rd, 32'h0003_0026);
    bus_read(2'd2, rd); check("rst_status", rd, 32'h0000_0002);

    // Ack is a single pulse even when the strobe is held.
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = 32'h4;
    @(posedge clk); @(negedge clk);
    check("ack_pulse_hi", 32'(ACK_O), 32'd1);
    @(posedge clk); @(negedge clk);
    check("ack_pulse_lo", 32'(ACK_O), 32'd0);
    CYC_I = 1'b0; STB_I = 1'b0;
    @(posedge clk); @(negedge clk);

    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, rd); check("reserved_rd", rd, 32'd0);
    bus_read(2'd0, rd); check("txdata_rd", rd, 32'd0);

    // Single frame, LSB first, two clocks per bit.
    bus_write(2'd1, 32'h0001_0027);
    bus_read(2'd1, rd); check("ctrl_rb", rd, 32'h0001_0027);
    bus_write(2'd0, 32'h0003_0201);
    n_ack = last_ack;
    exp_q.delete(); append_zeros(2); append_frame(32'h0003_0201, 9, 1, 1'b1); append_zeros(4);
    compare_stream("single_frame", n_ack);

    // MSB first, 4-bit frame, one clock per bit.
    bus_write(2'd1, 32'h0000_000D);
    bus_write(2'd0, 32'h0000_000A);
    n_ack = last_ack;
    exp_q.delete(); append_zeros(2); append_frame(32'hA, 3, 0, 1'b0); append_zeros(3);
    compare_stream("msb_short", n_ack);

    // Back-to-back frames with level tracking.
    bus_write(2'd1, ctrl_val(1, 7, 1'b1, 1'b0));
    for (int i = 1; i <= 8; i++) bus_write(2'd0, 32'(i));
    bus_read(2'd2, rd); check("b2b_full", rd, status_val(8, 1'b0, 1'b0));
    bus_write(2'd1, ctrl_val(1, 7, 1'b1, 1'b1));
    n_ack = last_ack;
    f = 8 * 2 + 2;
    exp_q.delete(); append_zeros(2);
    for (int i = 1; i <= 8; i++) append_frame(32'(i), 7, 1, 1'b1);
    append_zeros(3);
    for (int r = 0; r < 3; r++) begin
      bus_read(2'd2, rd);
      m = last_ack;
      pops = 0;
      for (int k = 0; k < 8; k++) if (n_ack + 1 + k * f < m) pops++;
      bsy = (m > n_ack + 1) && (m <= n_ack + 1 + 8 * f);
      check("b2b_level", rd, status_val(8 - pops, 1'b0, bsy));
      repeat (f) @(negedge clk);
    end
    compare_stream("b2b_stream", n_ack);

    // Overflow, sticky flag, W1C, and push coinciding with a pop while full.
    bus_write(2'd1, ctrl_val(1, 3, 1'b1, 1'b0));
    for (int i = 1; i <= 9; i++) bus_write(2'd0, 32'(i));
    bus_read(2'd2, rd); check("ovf_status", rd, 32'h0000_080C);
    bus_write(2'd2, 32'h8);
    bus_read(2'd2, rd); check("ovf_clear", rd, 32'h0000_0804);
    bus_write(2'd1, ctrl_val(1, 3, 1'b1, 1'b1));
    n_ack = last_ack;
    f = 4 * 2 + 2;
    wa = $urandom(); wb = $urandom();
    bus_write(2'd0, wa);
    while (tr.size() - 1 < n_ack + f) @(negedge clk);
    bus_write(2'd0, wb);
    bus_read(2'd2, rd); check("ovf_pop_same_cycle", rd & 32'h8, 32'h0);
    exp_q.delete(); append_zeros(2);
    for (int i = 1; i <= 8; i++) append_frame(32'(i), 3, 1, 1'b1);
    append_frame(wa, 3, 1, 1'b1); append_frame(wb, 3, 1, 1'b1);
    append_zeros(3);
    compare_stream("ovf_stream", n_ack);

    // Randomized configurations, including lengths that clamp to 32 bits.
    for (int it = 0; it < 4; it++) begin
      len = $urandom_range(40, 0); dv = $urandom_range(2, 0); lsb = 1'($urandom_range(1, 0));
      nw = $urandom_range(4, 1);
      words.delete();
      bus_write(2'd1, ctrl_val(dv, len, lsb, 1'b0));
      for (int i = 0; i < nw; i++) begin
        words.push_back($urandom());
        bus_write(2'd0, words[i]);
      end
      bus_write(2'd1, ctrl_val(dv, len, lsb, 1'b1));
      n_ack = last_ack;
      exp_q.delete(); append_zeros(2);
      foreach (words[i]) append_frame(words[i], len, dv, lsb);
      append_zeros(3);
      compare_stream("rand_stream", n_ack);
    end

    // Reset in the middle of a frame.
    bus_write(2'd1, 32'h0003_0027);
    bus_write(2'd0, $urandom());
    bus_write(2'd0, $urandom());
    cnt = 0;
    while (ena_o !== 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("mid_ena_seen", 32'(ena_o), 32'd1);
    repeat (5) @(negedge clk);
    rst_i = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_ena", 32'(ena_o), 32'd0);
    check("mid_rst_data", 32'(data_o), 32'd0);
    @(negedge clk); @(posedge clk); @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    bus_read(2'd2, rd); check("mid_rst_status", rd, 32'h0000_0002);
    bus_read(2'd1, rd); check("mid_rst_ctrl", rd, 32'h0003_0026);
    m = tr.size();
    repeat (60) @(negedge clk);
    cnt = 0;
    for (int i = m; i < tr.size(); i++) if (tr[i][1] !== 1'b0) cnt++;
    check("no_resume", 32'(cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
